// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//
// Parametrised counting core with a runtime modulus. It supports up, down,
// ping-pong and hold modes, a synchronous load, a registered terminal-count
// pulse and a sticky overflow flag.
//
// Optional feature (compile-time macro COUNTER_PRESCALE_EN):
//   When the macro is defined, a PRESCALE_W-bit prescaler gates the count so
//   that it steps once every presc_div+1 enabled cycles. When the macro is
//   undefined, the counter steps on every enabled cycle and presc_div is
//   ignored.
//
// Ports:
//   clk       system clock; all logic is rising-edge
//   rst       synchronous active-high reset
//   en        count enable; low freezes count, prescaler and tc
//   mode      00 up, 01 down, 10 ping-pong, 11 hold
//   load      synchronous load strobe (ignores en)
//   load_val  value to load; clamped to limit
//   limit     terminal value; the count range is 0..limit
//   clr_ovf   clears the sticky ovf flag (a concurrent tc wins)
//   presc_div step every presc_div+1 enabled cycles (prescaler builds only)
//   count     current count, registered
//   dir       0 = up, 1 = down
//   tc        one-cycle terminal-count pulse, registered
//   ovf       sticky flag, set by any tc
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clr_ovf,
  input  logic [PRESCALE_W-1:0] presc_div,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             dir_reg, dir_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             tick;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  // Prescaler counts enabled cycles; the terminal value produces the tick
  // and the prescaler wraps back to zero on the same edge.
  logic [PRESCALE_W-1:0] presc_reg, presc_next;

  assign tick = (presc_reg == presc_div);

  always_comb begin
    presc_next = presc_reg;
    if (load) begin
      presc_next = '0;
    end else if (en) begin
      presc_next = tick ? '0 : presc_reg + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end
`else
  // No prescaler: every enabled cycle is a tick. presc_div is kept on the
  // port list so the wrapper does not change between builds.
  logic unused_presc_div;
  assign unused_presc_div = ^presc_div;
  assign tick = 1'b1;
`endif

  assign step = en & tick & (mode != MODE_HOLD);

  always_comb begin
    count_next = count_reg;
    dir_next   = dir_reg;
    tc_next    = 1'b0;

    if (load) begin
      count_next = (load_val > limit) ? limit : load_val;
      dir_next   = (mode == MODE_DOWN);
    end else if (step) begin
      case (mode)
        MODE_UP: begin
          dir_next = 1'b0;
          if (count_reg >= limit) begin
            count_next = '0;
            tc_next    = 1'b1;
          end else begin
            count_next = count_reg + ONE;
          end
        end
        MODE_DOWN: begin
          dir_next = 1'b1;
          if (count_reg == '0) begin
            count_next = limit;
            tc_next    = 1'b1;
          end else if (count_reg > limit) begin
            // Limit was lowered below the count: snap back into range.
            count_next = limit;
          end else begin
            count_next = count_reg - ONE;
          end
        end
        MODE_PING: begin
          if (!dir_reg) begin
            if (count_reg >= limit) begin
              dir_next   = 1'b1;
              count_next = (limit == '0) ? '0 : limit - ONE;
              tc_next    = 1'b1;
            end else begin
              count_next = count_reg + ONE;
            end
          end else begin
            if (count_reg == '0) begin
              dir_next   = 1'b0;
              count_next = (limit == '0) ? '0 : ONE;
              tc_next    = 1'b1;
            end else if (count_reg > limit) begin
              count_next = limit;
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        default: begin
          // Hold never reaches here because step excludes it.
        end
      endcase
    end

    // A terminal count on this edge wins over a concurrent clear.
    ovf_next = tc_next | (ovf_reg & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign dir   = dir_reg;
  assign tc    = tc_reg;
  assign ovf   = ovf_reg;

endmodule
